// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-to-read bypass and a per-register
// busy scoreboard tracking outstanding producers for hazard detection.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ok,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_cnt,
  output logic              err_waw
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_pending_cnt;
  logic              r_err_waw;

  logic              w_wr_ok;
  logic              w_iss_zero;
  logic              w_iss_ok;
  logic              w_inc;
  logic              w_dec;
  logic              w_err_nxt;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;

  assign w_wr_ok    = wr_en & ~(ZERO_REG & (wr_addr == '0));
  assign w_iss_zero = ZERO_REG & (iss_addr == '0);

  // A busy target is still issuable when its producer retires this very cycle.
  assign w_iss_ok = iss_en & ~flush & ~w_iss_zero &
                    (~r_busy[iss_addr] | (wr_en & (wr_addr == iss_addr)));

  assign w_inc     = w_iss_ok & ~r_busy[iss_addr];
  assign w_dec     = w_wr_ok & r_busy[wr_addr] & ~(w_iss_ok & (iss_addr == wr_addr));
  assign w_err_nxt = iss_en & ~flush & ~w_iss_zero & r_busy[iss_addr] &
                     ~(wr_en & (wr_addr == iss_addr));

  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy_nxt[i] = flush ? 1'b0 :
                      (w_iss_ok && (iss_addr == ADDR_W'(i))) ? 1'b1 :
                      (w_wr_ok  && (wr_addr  == ADDR_W'(i))) ? 1'b0 :
                      r_busy[i];
    end
    w_cnt_nxt = flush ? '0 :
                r_pending_cnt + (ADDR_W + 1)'(w_inc) - (ADDR_W + 1)'(w_dec);
  end

  always_comb begin
    rd_data_a = r_regs[rd_addr_a];
    if (ZERO_REG && (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end else if (BYPASS && w_wr_ok && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = r_regs[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = r_regs[rd_addr_b];
    if (ZERO_REG && (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end else if (BYPASS && w_wr_ok && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = r_regs[rd_addr_b];
    end
  end

  assign rd_busy_a = r_busy[rd_addr_a] & ~(BYPASS & wr_en & (wr_addr == rd_addr_a));
  assign rd_busy_b = r_busy[rd_addr_b] & ~(BYPASS & wr_en & (wr_addr == rd_addr_b));

  assign iss_ok      = w_iss_ok;
  assign pending_cnt = r_pending_cnt;
  assign err_waw     = r_err_waw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy        <= '0;
      r_pending_cnt <= '0;
      r_err_waw     <= 1'b0;
    end else begin
      r_busy        <= w_busy_nxt;
      r_pending_cnt <= w_cnt_nxt;
      r_err_waw     <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a default 32x32 instance driven from a vector table, and a
// 16x64 instance without zero register or bypass driven by hand sequences.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance (DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1)
  logic [4:0]  ra, rb, wr_addr, iss_addr;
  logic [31:0] rda, rdb, wr_data;
  logic        ba, bb, wr_en, iss_en, iss_ok, flush, err;
  logic [5:0]  cnt;

  regfile_scoreboard u_dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda), .rd_data_b(rdb),
    .rd_busy_a(ba), .rd_busy_b(bb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok),
    .flush(flush), .pending_cnt(cnt), .err_waw(err)
  );

  // Alternate instance (DATA_W=64, ADDR_W=4, ZERO_REG=0, BYPASS=0)
  logic [3:0]  a_ra, a_rb, a_wr_addr, a_iss_addr;
  logic [63:0] a_rda, a_rdb, a_wr_data;
  logic        a_ba, a_bb, a_wr_en, a_iss_en, a_iss_ok, a_flush, a_err;
  logic [4:0]  a_cnt;

  regfile_scoreboard #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
    .clk(clk), .rst(rst),
    .rd_addr_a(a_ra), .rd_addr_b(a_rb), .rd_data_a(a_rda), .rd_data_b(a_rdb),
    .rd_busy_a(a_ba), .rd_busy_b(a_bb),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_addr(a_iss_addr), .iss_ok(a_iss_ok),
    .flush(a_flush), .pending_cnt(a_cnt), .err_waw(a_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [4:0]  ra, rb;
    logic        e_ok;
    logic [31:0] e_da;
    logic        e_ba;
    logic [31:0] e_db;
    logic        e_bb;
    logic [5:0]  e_cnt;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic ie, input logic [4:0] ia, input logic fl,
    input logic [4:0] a, input logic [4:0] b,
    input logic ok, input logic [31:0] da, input logic bsa,
    input logic [31:0] db, input logic bsb, input logic [5:0] c, input logic e);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.iss_en = ie; v.iss_addr = ia; v.flush = fl; v.ra = a; v.rb = b;
    v.e_ok = ok; v.e_da = da; v.e_ba = bsa; v.e_db = db; v.e_bb = bsb;
    v.e_cnt = c; v.e_err = e;
    return v;
  endfunction

  task automatic idle_main();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    iss_en = 1'b0; iss_addr = 5'd0; flush = 1'b0;
  endtask

  task automatic idle_alt();
    a_wr_en = 1'b0; a_wr_addr = 4'd0; a_wr_data = 64'd0;
    a_iss_en = 1'b0; a_iss_addr = 4'd0; a_flush = 1'b0;
  endtask

  localparam int NV = 22;
  vec_t tbl [NV];

  initial begin
    // Each row: inputs held for one cycle; outputs sampled before that cycle's edge.
    tbl[0]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 1'b0);
    tbl[1]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 1'b0);
    tbl[2]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 6'd1, 1'b0);
    tbl[3]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 6'd1, 1'b0);
    tbl[4]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 6'd0, 1'b0);
    tbl[5]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 6'd0, 1'b0);
    tbl[6]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 6'd1, 1'b0);
    tbl[7]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 6'd1, 1'b1);
    tbl[8]  = mk(1'b1, 5'd7, 32'h12,       1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 1'b1, 32'h12,       1'b0, 32'h0,        1'b0, 6'd1, 1'b0);
    tbl[9]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b0, 32'h12,       1'b1, 32'h0,        1'b0, 6'd1, 1'b0);
    tbl[10] = mk(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 6'd1, 1'b0);
    tbl[11] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 1'b0, 32'h0,        1'b0, 32'h12,       1'b1, 6'd1, 1'b0);
    tbl[12] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 1'b0, 5'd1, 5'd0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 6'd1, 1'b0);
    tbl[13] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 5'd1, 5'd0, 1'b1, 32'h0,        1'b1, 32'h0,        1'b0, 6'd2, 1'b0);
    tbl[14] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd2, 5'd3, 1'b1, 32'h0,        1'b1, 32'h0,        1'b0, 6'd3, 1'b0);
    tbl[15] = mk(1'b1, 5'd9, 32'h55,       1'b1, 5'd4, 1'b1, 5'd9, 5'd4, 1'b0, 32'h55,       1'b0, 32'h0,        1'b0, 6'd4, 1'b0);
    tbl[16] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd4, 1'b0, 32'h55,       1'b0, 32'h0,        1'b0, 6'd0, 1'b0);
    tbl[17] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd3, 1'b0, 32'h12,       1'b0, 32'h0,        1'b0, 6'd0, 1'b0);
    tbl[18] = mk(1'b1, 5'd9, 32'h66,       1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 1'b0, 32'h66,       1'b0, 32'h0,        1'b0, 6'd0, 1'b0);
    tbl[19] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd5, 1'b0, 32'h66,       1'b0, 32'hDEADBEEF, 1'b0, 6'd0, 1'b0);
    tbl[20] = mk(1'b1, 5'd6, 32'hA,        1'b1, 5'd6, 1'b0, 5'd6, 5'd0, 1'b1, 32'hA,        1'b0, 32'h0,        1'b0, 6'd0, 1'b0);
    tbl[21] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd6, 5'd0, 1'b0, 32'hA,        1'b1, 32'h0,        1'b0, 6'd1, 1'b0);

    idle_main(); idle_alt();
    ra = 5'd0; rb = 5'd0; a_ra = 4'd0; a_rb = 4'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cnt", {58'd0, cnt}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ra = 5'(i); rb = 5'(31 - i);
      #1;
      chk($sformatf("init_rda[%0d]", i), {32'd0, rda}, 64'd0);
      chk($sformatf("init_rdb[%0d]", 31 - i), {32'd0, rdb}, 64'd0);
      chk($sformatf("init_busy[%0d]", i), {62'd0, ba, bb}, 64'd0);
    end
    chk("init_cnt", {58'd0, cnt}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
      iss_en = tbl[i].iss_en; iss_addr = tbl[i].iss_addr; flush = tbl[i].flush;
      ra = tbl[i].ra; rb = tbl[i].rb;
      #1;
      chk($sformatf("row%0d_iss_ok", i), {63'd0, iss_ok}, {63'd0, tbl[i].e_ok});
      chk($sformatf("row%0d_rda", i), {32'd0, rda}, {32'd0, tbl[i].e_da});
      chk($sformatf("row%0d_busy_a", i), {63'd0, ba}, {63'd0, tbl[i].e_ba});
      chk($sformatf("row%0d_rdb", i), {32'd0, rdb}, {32'd0, tbl[i].e_db});
      chk($sformatf("row%0d_busy_b", i), {63'd0, bb}, {63'd0, tbl[i].e_bb});
      chk($sformatf("row%0d_cnt", i), {58'd0, cnt}, {58'd0, tbl[i].e_cnt});
      chk($sformatf("row%0d_err", i), {63'd0, err}, {63'd0, tbl[i].e_err});
    end
    @(negedge clk);
    idle_main();

    // Alternate instance: r0 is ordinary and writes are not forwarded.
    a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 64'hFFFFFFFF_FFFFFFFF;
    a_iss_en = 1'b1; a_iss_addr = 4'd0; a_ra = 4'd0;
    #1;
    chk("alt_iss_ok_r0", {63'd0, a_iss_ok}, 64'd1);
    chk("alt_nobypass_data", a_rda, 64'd0);
    chk("alt_nobypass_busy", {63'd0, a_ba}, 64'd0);
    @(negedge clk);
    idle_alt();
    #1;
    chk("alt_r0_data", a_rda, 64'hFFFFFFFF_FFFFFFFF);
    chk("alt_r0_busy", {63'd0, a_ba}, 64'd1);
    chk("alt_cnt1", {59'd0, a_cnt}, 64'd1);
    @(negedge clk);
    a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 64'h1234;
    #1;
    chk("alt_wb_still_busy", {63'd0, a_ba}, 64'd1);
    chk("alt_wb_old_data", a_rda, 64'hFFFFFFFF_FFFFFFFF);
    @(negedge clk);
    idle_alt();
    #1;
    chk("alt_wb_data", a_rda, 64'h1234);
    chk("alt_wb_busy", {63'd0, a_ba}, 64'd0);
    chk("alt_cnt0", {59'd0, a_cnt}, 64'd0);
    @(negedge clk);
    a_iss_en = 1'b1; a_iss_addr = 4'd15;
    @(negedge clk);
    idle_alt();
    a_ra = 4'd15; a_rb = 4'd0;
    #1;
    chk("alt_r15_busy", {63'd0, a_ba}, 64'd1);
    chk("alt_cnt_r15", {59'd0, a_cnt}, 64'd1);

    // Main: r3 busy holding 0x77, then a WAW reject so err_waw is high.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    iss_en = 1'b1; iss_addr = 5'd3;
    @(negedge clk);
    idle_main();
    iss_en = 1'b1; iss_addr = 5'd3;
    #1;
    chk("pre_waw_iss_ok", {63'd0, iss_ok}, 64'd0);
    @(negedge clk);
    idle_main();
    ra = 5'd3; rb = 5'd6;
    #1;
    chk("pre_rst_data", {32'd0, rda}, 64'h77);
    chk("pre_rst_busy", {63'd0, ba}, 64'd1);
    chk("pre_rst_cnt", {58'd0, cnt}, 64'd2);
    chk("pre_rst_err", {63'd0, err}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_data", {32'd0, rda}, 64'd0);
    chk("arst_busy_a", {63'd0, ba}, 64'd0);
    chk("arst_data_b", {32'd0, rdb}, 64'd0);
    chk("arst_busy_b", {63'd0, bb}, 64'd0);
    chk("arst_cnt", {58'd0, cnt}, 64'd0);
    chk("arst_err", {63'd0, err}, 64'd0);
    chk("arst_alt_busy", {63'd0, a_ba}, 64'd0);
    chk("arst_alt_data", a_rdb, 64'd0);
    chk("arst_alt_cnt", {59'd0, a_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
